pill_schedule_timer: RTL and testbench

- Upstream feeder of the LCD display stage in the pill-dispenser design.
- Latches one patient's ROM record and runs three per-pill countdowns, in 1-digit BCD units.
- Drives the remaining-time nibbles the display shows, and raises per-pill due flags.
- Escalates to a missed-dose scene: it drives monitorOrMissedScene, which freezes the display stage.

---
 rtl/pill_sched_pkg.sv | 35 +++
 rtl/pill_schedule_timer_pill_countdown.sv | 120 ++++++++++++
 rtl/pill_schedule_timer.sv | 154 +++++++++++++++
 tb/tb_pill_schedule_timer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pill_sched_pkg.sv
// ---------------------------------------------------------------------------
// pill_sched_pkg
// Shared definitions for the pill schedule timer:
//   - scheduler state encoding (IDLE / RUN / MISSED)
//   - romContent field bit positions
//   - BCD maximum digit value and interval clamp helper
//   - default TICK_DIV and MISS_TIMEOUT values
// ---------------------------------------------------------------------------
package pill_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_MISSED = 2'd2
    } state_e;

    localparam int unsigned DEF_TICK_DIV     = 400;
    localparam int unsigned DEF_MISS_TIMEOUT = 5;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // romContent layout: [27:24] patient, then three {id, interval} byte pairs.
    // Pill n (0-based) has its interval nibble at PILL_INT_LSB0 - n*PILL_FIELD_STRIDE
    // and its id nibble four bits above that.
    localparam int PATIENT_LSB       = 24;
    localparam int PILL_INT_LSB0     = 16;
    localparam int PILL_FIELD_STRIDE = 8;
    localparam int PILL_ID_OFFSET    = 4;

    // Interval nibbles are single BCD digits; anything above 9 saturates.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/pill_schedule_timer_pill_countdown.sv
// ---------------------------------------------------------------------------
// pill_countdown
// One pill's schedule: reload register, remaining-time countdown, due flag,
// overdue counter and missed flag.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   interval_i     clamped interval nibble, latched when reload_i is high
//   reload_i       latch interval_i and restart this pill (clears due/miss)
//   tick_i         one countdown unit elapsed (only while scheduler runs)
//   ack_i          take_pill for this pill (only while scheduler runs)
//   clear_i        leave missed scene: a missed pill is reloaded
//   freeze_i       hold countdown/overdue state
//   remaining_o    remaining units (BCD digit)
//   due_o          countdown reached 0, not yet acknowledged
//   missed_o       overdue counter reached MISS_TIMEOUT
//   miss_event_o   combinational: missed_o is being set on this edge
// ---------------------------------------------------------------------------
module pill_countdown
    import pill_sched_pkg::*;
#(
    parameter int unsigned MISS_TIMEOUT = DEF_MISS_TIMEOUT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] interval_i,
    input  logic       reload_i,
    input  logic       tick_i,
    input  logic       ack_i,
    input  logic       clear_i,
    input  logic       freeze_i,
    output logic [3:0] remaining_o,
    output logic       due_o,
    output logic       missed_o,
    output logic       miss_event_o
);

    logic [3:0] reload_val_q, reload_val_d;
    logic [3:0] remaining_q, remaining_d;
    logic [3:0] overdue_q, overdue_d;
    logic       due_q, due_d;
    logic       missed_q, missed_d;

    logic enabled;
    logic expiring;
    logic ack_take;
    logic timeout;

    // A zero interval disables the pill entirely.
    assign enabled  = (reload_val_q != 4'd0);
    assign expiring = tick_i && (remaining_q == 4'd1);
    // An acknowledge is honoured while due, and also on the tick that would
    // make the pill due: the take wins over both expiry and timeout.
    assign ack_take = ack_i && enabled && (due_q || expiring);
    assign timeout  = tick_i && due_q && (({1'b0, overdue_q} + 5'd1) == 5'(MISS_TIMEOUT));

    assign miss_event_o = !freeze_i && !reload_i && !ack_take && timeout;

    always_comb begin
        reload_val_d = reload_val_q;
        remaining_d  = remaining_q;
        overdue_d    = overdue_q;
        due_d        = due_q;
        missed_d     = missed_q;
        if (reload_i) begin
            reload_val_d = interval_i;
            remaining_d  = interval_i;
            overdue_d    = 4'd0;
            due_d        = 1'b0;
            missed_d     = 1'b0;
        end else if (clear_i) begin
            if (missed_q) begin
                remaining_d = reload_val_q;
                overdue_d   = 4'd0;
                due_d       = 1'b0;
                missed_d    = 1'b0;
            end
        end else if (!freeze_i) begin
            if (ack_take) begin
                remaining_d = reload_val_q;
                overdue_d   = 4'd0;
                due_d       = 1'b0;
            end else if (tick_i && enabled) begin
                if (remaining_q != 4'd0) begin
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        due_d = 1'b1;
                    end
                end else if (due_q) begin
                    overdue_d = overdue_q + 4'd1;
                    if (timeout) begin
                        missed_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            reload_val_q <= 4'd0;
            remaining_q  <= 4'd0;
            overdue_q    <= 4'd0;
            due_q        <= 1'b0;
            missed_q     <= 1'b0;
        end else begin
            reload_val_q <= reload_val_d;
            remaining_q  <= remaining_d;
            overdue_q    <= overdue_d;
            due_q        <= due_d;
            missed_q     <= missed_d;
        end
    end

    assign remaining_o = remaining_q;
    assign due_o       = due_q;
    assign missed_o    = missed_q;

endmodule

// File: rtl/pill_schedule_timer.sv
// ---------------------------------------------------------------------------
// pill_schedule_timer
// Latches one patient record, runs three per-pill BCD countdowns, flags due
// and missed pills, and drives the missed scene that freezes the display.
//
// Ports:
//   CLK_400Hz            clock
//   resetn               synchronous active-low reset
//   load                 latch romContent and (re)start the schedule
//   romContent[27:0]     patient / pill id / pill interval fields
//   take_pill[2:0]       acknowledge a due pill (bit0 = pill1)
//   clear_missed         leave the missed scene
//   pill12And3Duration   remaining units: [11:8] pill1, [7:4] pill2, [3:0] pill3
//   pill_due[2:0]        per-pill due flags
//   missed_pills[2:0]    per-pill missed flags
//   monitorOrMissedScene 1 while in the missed scene
//   missed_count[3:0]    BCD count of missed-scene entries, saturating at 9
//
// Build option: define PILL_MISSED_COUNT_EN to implement missed_count;
// otherwise it reads 0 and has no register.
// ---------------------------------------------------------------------------
module pill_schedule_timer
    import pill_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned MISS_TIMEOUT = DEF_MISS_TIMEOUT
) (
    input  logic        CLK_400Hz,
    input  logic        resetn,
    input  logic        load,
    input  logic [27:0] romContent,
    input  logic [2:0]  take_pill,
    input  logic        clear_missed,
    output logic [11:0] pill12And3Duration,
    output logic [2:0]  pill_due,
    output logic [2:0]  missed_pills,
    output logic        monitorOrMissedScene,
    output logic [3:0]  missed_count
);

    state_e      state_q, state_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;

    logic        in_run;
    logic        tick;
    logic        reload;
    logic        clear;
    logic [2:0]  miss_event;

    assign in_run = (state_q == ST_RUN);
    // A load in RUN restarts everything, so it also suppresses the tick.
    assign tick   = in_run && !load && (tick_cnt_q == 16'(TICK_DIV - 1));
    assign reload = load && (state_q != ST_MISSED);
    assign clear  = clear_missed && (state_q == ST_MISSED);

    // Patient and pill-id fields are carried in the record but not used here.
    logic unused_rom_fields;
    assign unused_rom_fields = ^{romContent[PATIENT_LSB +: 4],
                                 romContent[PILL_INT_LSB0 + PILL_ID_OFFSET +: 4],
                                 romContent[PILL_INT_LSB0 - PILL_FIELD_STRIDE + PILL_ID_OFFSET +: 4],
                                 romContent[PILL_INT_LSB0 - 2*PILL_FIELD_STRIDE + PILL_ID_OFFSET +: 4]};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pill
            pill_countdown #(
                .MISS_TIMEOUT (MISS_TIMEOUT)
            ) u_pill (
                .clk_i        (CLK_400Hz),
                .rst_ni       (resetn),
                .interval_i   (bcd_clamp(romContent[PILL_INT_LSB0 - gi*PILL_FIELD_STRIDE +: 4])),
                .reload_i     (reload),
                .tick_i       (tick),
                .ack_i        (take_pill[gi] && in_run),
                .clear_i      (clear),
                .freeze_i     (!in_run),
                .remaining_o  (pill12And3Duration[(2-gi)*4 +: 4]),
                .due_o        (pill_due[gi]),
                .missed_o     (missed_pills[gi]),
                .miss_event_o (miss_event[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge CLK_400Hz) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d    = ST_RUN;
                    tick_cnt_d = 16'd0;
                end
            end
            ST_RUN: begin
                if (load) begin
                    tick_cnt_d = 16'd0;
                end else begin
                    tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;
                    if (|miss_event) begin
                        state_d = ST_MISSED;
                    end
                end
            end
            ST_MISSED: begin
                if (clear_missed) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic (decoded from the state register only)
    always_comb begin
        monitorOrMissedScene = (state_q == ST_MISSED);
    end

`ifdef PILL_MISSED_COUNT_EN
    logic [3:0] missed_count_q, missed_count_d;

    always_comb begin
        missed_count_d = missed_count_q;
        if (in_run && (state_d == ST_MISSED) && (missed_count_q < BCD_MAX)) begin
            missed_count_d = missed_count_q + 4'd1;
        end
    end

    always_ff @(posedge CLK_400Hz) begin
        if (!resetn) begin
            missed_count_q <= 4'd0;
        end else begin
            missed_count_q <= missed_count_d;
        end
    end

    assign missed_count = missed_count_q;
`else
    assign missed_count = 4'h0;
`endif

endmodule

// File: tb/tb_pill_schedule_timer.sv
module tb_pill_schedule_timer;

    localparam int TD = 4;
    localparam int MT = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b0;
    logic [27:0] romContent = 28'h0;
    logic [2:0]  take_pill = 3'b000;
    logic        clear_missed = 1'b0;
    logic [11:0] pill12And3Duration;
    logic [2:0]  pill_due;
    logic [2:0]  missed_pills;
    logic        monitorOrMissedScene;
    logic [3:0]  missed_count;

    always #5 clk = ~clk;

    pill_schedule_timer #(
        .TICK_DIV     (TD),
        .MISS_TIMEOUT (MT)
    ) dut (
        .CLK_400Hz            (clk),
        .resetn               (resetn),
        .load                 (load),
        .romContent           (romContent),
        .take_pill            (take_pill),
        .clear_missed         (clear_missed),
        .pill12And3Duration   (pill12And3Duration),
        .pill_due             (pill_due),
        .missed_pills         (missed_pills),
        .monitorOrMissedScene (monitorOrMissedScene),
        .missed_count         (missed_count)
    );

    typedef struct {
        logic [11:0] dur;
        logic [2:0]  due;
        logic [2:0]  missed;
        logic        scene;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Behavioural model: mode 0=idle, 1=running, 2=missed scene
    int m_mode = 0;
    int m_cnt = 0;
    int m_count = 0;
    int m_rem[3] = '{0, 0, 0};
    int m_rel[3] = '{0, 0, 0};
    int m_od[3]  = '{0, 0, 0};
    bit m_due[3] = '{0, 0, 0};
    bit m_missed[3] = '{0, 0, 0};

    task automatic model_latch(input logic [27:0] rom);
        for (int i = 0; i < 3; i++) begin
            int v;
            v = int'((rom >> (16 - 8 * i)) & 28'hF);
            if (v > 9) v = 9;
            m_rel[i] = v;
            m_rem[i] = v;
            m_od[i] = 0;
            m_due[i] = 0;
            m_missed[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_step(input bit rn, input bit ld, input logic [27:0] rom,
                              input logic [2:0] tk, input bit clr);
        bit tick_now;
        bit any_miss;
        if (!rn) begin
            m_mode = 0; m_cnt = 0; m_count = 0;
            for (int i = 0; i < 3; i++) begin
                m_rem[i] = 0; m_rel[i] = 0; m_od[i] = 0; m_due[i] = 0; m_missed[i] = 0;
            end
            return;
        end
        if (m_mode == 0) begin
            if (ld) begin
                model_latch(rom);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (ld) begin
                model_latch(rom);
            end else begin
                tick_now = (m_cnt == TD - 1);
                m_cnt = tick_now ? 0 : m_cnt + 1;
                any_miss = 0;
                for (int i = 0; i < 3; i++) begin
                    if (m_rel[i] != 0) begin
                        if (tk[i] && (m_due[i] || (tick_now && m_rem[i] == 1))) begin
                            m_rem[i] = m_rel[i]; m_due[i] = 0; m_od[i] = 0;
                        end else if (tick_now) begin
                            if (m_rem[i] > 0) begin
                                m_rem[i]--;
                                if (m_rem[i] == 0) m_due[i] = 1;
                            end else if (m_due[i]) begin
                                m_od[i]++;
                                if (m_od[i] == MT) begin
                                    m_missed[i] = 1;
                                    any_miss = 1;
                                end
                            end
                        end
                    end
                end
                if (any_miss) begin
                    m_mode = 2;
`ifdef PILL_MISSED_COUNT_EN
                    if (m_count < 9) m_count++;
`endif
                end
            end
        end else begin
            if (clr) begin
                for (int i = 0; i < 3; i++) begin
                    if (m_missed[i]) begin
                        m_rem[i] = m_rel[i]; m_due[i] = 0; m_od[i] = 0; m_missed[i] = 0;
                    end
                end
                m_mode = 1;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.dur    = {4'(m_rem[0]), 4'(m_rem[1]), 4'(m_rem[2])};
        e.due    = {m_due[2], m_due[1], m_due[0]};
        e.missed = {m_missed[2], m_missed[1], m_missed[0]};
        e.scene  = (m_mode == 2);
        e.cnt    = 4'(m_count);
        return e;
    endfunction

    task automatic drive(input bit rn, input bit ld, input logic [27:0] rom,
                         input logic [2:0] tk, input bit clr);
        @(negedge clk);
        resetn = rn; load = ld; romContent = rom; take_pill = tk; clear_missed = clr;
        model_step(rn, ld, rom, tk, clr);
        sb_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 28'h0, 3'b000, 1'b0);
    endtask

    task automatic bound_fail(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, model mode %0d", what, m_mode);
    endtask

    task automatic wait_mode(input int want, input int budget, input string what);
        int k;
        k = 0;
        while (m_mode != want && k < budget) begin
            idle(1);
            k++;
        end
        if (m_mode != want) bound_fail(what);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s txn %0d: got %0h, expected %0h", name, n_txn, act, exp_v);
        end
    endtask

    // Monitor: the DUT presents a new output set every clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("duration", 32'(pill12And3Duration), 32'(e.dur));
                chk("pill_due", 32'(pill_due), 32'(e.due));
                chk("missed_pills", 32'(missed_pills), 32'(e.missed));
                chk("scene", 32'(monitorOrMissedScene), 32'(e.scene));
                chk("missed_count", 32'(missed_count), 32'(e.cnt));
                $display("txn %0d dur=%03h due=%b missed=%b scene=%b cnt=%0d",
                         n_txn, pill12And3Duration, pill_due, missed_pills,
                         monitorOrMissedScene, missed_count);
                n_txn++;
            end
        end
    end

    initial begin
        int k;
        // Reset, then load the reference record
        drive(1'b0, 1'b0, 28'h0, 3'b000, 1'b0);
        drive(1'b0, 1'b0, 28'h0, 3'b000, 1'b0);
        drive(1'b1, 1'b1, 28'h1_13_25_30, 3'b000, 1'b0);
        idle(10);

        // Expiry then acknowledge
        drive(1'b1, 1'b1, 28'h0_11_02_00, 3'b000, 1'b0);
        idle(4);
        drive(1'b1, 1'b0, 28'h0, 3'b001, 1'b0);
        idle(2);

        // Miss path: leave pills due, freeze, then clear
        wait_mode(2, 100, "miss_wait");
        idle(12);
        drive(1'b1, 1'b0, 28'h0, 3'b000, 1'b1);
        idle(3);

        // Race: take on the tick that would time pill1 out
        drive(1'b1, 1'b1, 28'h0_11_09_00, 3'b000, 1'b0);
        k = 0;
        while (!(m_mode == 1 && m_due[0] && m_od[0] == MT - 1 && m_cnt == TD - 1) && k < 100) begin
            idle(1);
            k++;
        end
        if (k >= 100) bound_fail("race_wait");
        drive(1'b1, 1'b0, 28'h0, 3'b001, 1'b0);
        idle(3);

        // Eleven misses for saturation
        drive(1'b1, 1'b1, 28'h0_11_00_00, 3'b000, 1'b0);
        for (int m = 0; m < 11; m++) begin
            wait_mode(2, 100, "sat_wait");
            drive(1'b1, 1'b0, 28'h0, 3'b000, 1'b1);
        end
        idle(2);

        // Clamp of an out-of-range nibble
        drive(1'b1, 1'b1, 28'h0_0C_0F_0A, 3'b000, 1'b0);
        idle(3);

        // Reset in the missed scene, then load alone restarts
        drive(1'b1, 1'b1, 28'h0_01_00_00, 3'b000, 1'b0);
        wait_mode(2, 100, "reset_wait");
        drive(1'b0, 1'b0, 28'h0, 3'b000, 1'b0);
        idle(3);
        drive(1'b1, 1'b1, 28'h1_13_25_30, 3'b000, 1'b0);
        idle(6);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            bit rn, ld, clr;
            logic [2:0] tk;
            logic [27:0] rom;
            rn  = ($urandom_range(0, 499) != 0);
            ld  = ($urandom_range(0, 79) == 0);
            rom = 28'($urandom);
            tk  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            clr = ($urandom_range(0, 7) == 0);
            drive(rn, ld, rom, tk, clr);
        end
        idle(2);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected transactions never compared, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
